// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a byte-addressed memory: lane expansion, bounds check, load extension.
// Define MAU_SIGN_EXT_EN to honour req_signed (sign-extended byte/half loads); otherwise all loads zero-extend.
module mem_access_unit #(
   parameter int MEM_SIZE = 125,
   parameter int ADDR_W   = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_fault,
   output logic [1:0]            mem_control,
   output logic [4*ADDR_W-1:0]   mem_address,
   output logic [31:0]           mem_write,
   input  logic [31:0]           mem_read
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);

   state_t              state, state_next;
   logic [ADDR_W:0]     nbytes;
   logic [ADDR_W:0]     end_addr;
   logic                bad_req;
   logic [3:0]          lane_en;
   logic [4*ADDR_W-1:0] lanes;
   logic                write_q;
   logic [1:0]          size_q;
   logic [31:0]         load_data;

`ifdef MAU_SIGN_EXT_EN
   logic                signed_q;
`else
   logic                unused_signed;
   assign unused_signed = req_signed;
`endif

   // Request decode: byte count and range check, one bit wider than the address so overflow faults.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      nbytes = '0;
      case (req_size)
         2'd1:    nbytes = (ADDR_W+1)'(1);
         2'd2:    nbytes = (ADDR_W+1)'(2);
         2'd3:    nbytes = (ADDR_W+1)'(4);
         default: nbytes = '0;
      endcase
      end_addr = {1'b0, req_addr} + nbytes;
      bad_req  = (req_size == 2'd0) || (end_addr > MEM_LIMIT);
   end

   // Unused lanes repeat the base address so the memory never sees an out-of-range lane.
   always_comb begin
      lane_en = {req_size == 2'd3, req_size == 2'd3, req_size >= 2'd2, 1'b1};
      lanes   = '0;
      for (int k = 0; k < 4; k++) begin
         lanes[k*ADDR_W +: ADDR_W] = lane_en[k] ? req_addr + ADDR_W'(k) : req_addr;
      end
   end

   always_comb begin
      load_data = mem_read;
      case (size_q)
         2'd1: load_data = {24'd0, mem_read[7:0]};
         2'd2: load_data = {16'd0, mem_read[15:0]};
         default: load_data = mem_read;
      endcase
`ifdef MAU_SIGN_EXT_EN
      if (signed_q) begin
         case (size_q)
            2'd1: load_data = {{24{mem_read[7]}}, mem_read[7:0]};
            2'd2: load_data = {{16{mem_read[15]}}, mem_read[15:0]};
            default: load_data = mem_read;
         endcase
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid) state_next = bad_req ? RESP : ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == RESP);
   end

   // Memory-side outputs are loaded on accept and cleared as ACCESS closes, so they live exactly one cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         write_q     <= 1'b0;
         size_q      <= 2'd0;
         rsp_rdata   <= '0;
         rsp_fault   <= 1'b0;
         mem_control <= 2'd0;
         mem_address <= '0;
         mem_write   <= '0;
`ifdef MAU_SIGN_EXT_EN
         signed_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  write_q   <= req_write;
                  size_q    <= req_size;
`ifdef MAU_SIGN_EXT_EN
                  signed_q  <= req_signed;
`endif
                  rsp_fault <= bad_req;
                  rsp_rdata <= '0;
                  if (!bad_req) begin
                     mem_address <= lanes;
                     mem_write   <= req_wdata;
                     mem_control <= req_write ? req_size : 2'd0;
                  end
               end
            end
            ACCESS: begin
               mem_control <= 2'd0;
               mem_address <= '0;
               mem_write   <= '0;
               rsp_rdata   <= write_q ? 32'd0 : load_data;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_rdata <= '0;
                  rsp_fault <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios then randomized traffic against a
// byte-array reference model; a behavioural byte memory answers the unit's lane addresses.
module tb_mem_access_unit;

   localparam int MEM_SIZE = 125;
   localparam int ADDR_W   = 10;
`ifdef MAU_SIGN_EXT_EN
   localparam bit SIGN_EN = 1'b1;
`else
   localparam bit SIGN_EN = 1'b0;
`endif

   logic                clock = 1'b0;
   logic                reset;
   logic                req_valid, req_ready, req_write, req_signed;
   logic [1:0]          req_size;
   logic [ADDR_W-1:0]   req_addr;
   logic [31:0]         req_wdata;
   logic                rsp_valid, rsp_ready, rsp_fault;
   logic [31:0]         rsp_rdata;
   logic [1:0]          mem_control;
   logic [4*ADDR_W-1:0] mem_address;
   logic [31:0]         mem_write, mem_read;

   logic [7:0] mem     [MEM_SIZE];
   logic [7:0] ref_mem [MEM_SIZE];

   int checks = 0;
   int errors = 0;

   mem_access_unit #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_fault(rsp_fault),
      .mem_control(mem_control), .mem_address(mem_address),
      .mem_write(mem_write), .mem_read(mem_read)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] init_byte(int i);
      return 8'((i * 37 + 11) ^ (i >> 2));
   endfunction

   // External memory: combinational read per lane, write of mem_control-sized bytes at the clock edge.
   always_comb begin
      mem_read = '0;
      for (int k = 0; k < 4; k++) begin
         if (int'(mem_address[k*ADDR_W +: ADDR_W]) < MEM_SIZE)
            mem_read[8*k +: 8] = mem[mem_address[k*ADDR_W +: ADDR_W]];
      end
   end

   initial begin
      int nb;
      for (int i = 0; i < MEM_SIZE; i++) mem[i] = init_byte(i);
      forever begin
         @(posedge clock);
         nb = (mem_control == 2'd3) ? 4 : int'(mem_control);
         for (int k = 0; k < nb; k++) begin
            if (int'(mem_address[k*ADDR_W +: ADDR_W]) < MEM_SIZE)
               mem[mem_address[k*ADDR_W +: ADDR_W]] <= mem_write[8*k +: 8];
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int size_bytes(logic [1:0] sz);
      return (sz == 2'd3) ? 4 : int'(sz);
   endfunction

   function automatic logic [4*ADDR_W-1:0] exp_lanes(logic [ADDR_W-1:0] a, int n);
      logic [4*ADDR_W-1:0] r;
      r = '0;
      for (int k = 0; k < 4; k++)
         r[k*ADDR_W +: ADDR_W] = (k < n) ? ADDR_W'((int'(a) + k) % (1 << ADDR_W)) : a;
      return r;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ctl"},  64'(mem_control), 64'd0);
      check({tag, "_addr"}, 64'(mem_address), 64'd0);
      check({tag, "_wr"},   64'(mem_write),   64'd0);
   endtask

   // One full transaction, starting and ending 1 time unit after a rising edge with the unit idle.
   task automatic xact(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [ADDR_W-1:0] a, input logic [31:0] wd, input int hold);
      int          n;
      bit          fault;
      logic [63:0] acc;
      logic [31:0] exp_rd;
      n      = size_bytes(sz);
      fault  = (n == 0) || (int'(a) + n > MEM_SIZE);
      exp_rd = '0;
      if (!fault && !wr) begin
         acc = '0;
         for (int k = 0; k < n; k++) acc = acc + (64'(ref_mem[int'(a) + k]) << (8 * k));
         if (sg && SIGN_EN && n < 4 && acc[8*n-1]) acc = acc - (64'd1 << (8 * n));
         exp_rd = acc[31:0];
      end
      check("ready_before_req", 64'(req_ready), 64'd1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      rsp_ready  = (hold == 0);
      @(posedge clock); #1;
      // Busy-time request inputs must be ignored.
      req_valid  = 1'b1;
      req_write  = 1'($urandom);
      req_size   = 2'($urandom);
      req_addr   = ADDR_W'($urandom);
      req_wdata  = $urandom;
      if (!fault) begin
         check("access_ctl",   64'(mem_control), wr ? 64'(sz) : 64'd0);
         check("access_lanes", 64'(mem_address), 64'(exp_lanes(a, n)));
         check("access_wdata", 64'(mem_write),   64'(wd));
         check("access_rspv",  64'(rsp_valid),   64'd0);
         check("access_ready", 64'(req_ready),   64'd0);
         if (wr) for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
         @(posedge clock); #1;
      end
      for (int c = 0; c <= hold; c++) begin
         if (c > 0) begin
            @(posedge clock); #1;
         end
         check("resp_valid", 64'(rsp_valid), 64'd1);
         check("resp_fault", 64'(rsp_fault), 64'(fault));
         check("resp_rdata", 64'(rsp_rdata), 64'(exp_rd));
         check("resp_ready", 64'(req_ready), 64'd0);
         check_idle_outputs("resp");
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      check("back_idle_rspv",  64'(rsp_valid), 64'd0);
      check("back_idle_ready", 64'(req_ready), 64'd1);
   endtask

   initial begin
      int bad;
      for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = init_byte(i);
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_ready", 64'(req_ready), 64'd1);
      check("reset_rspv",  64'(rsp_valid), 64'd0);
      check("reset_rdata", 64'(rsp_rdata), 64'd0);
      check("reset_fault", 64'(rsp_fault), 64'd0);
      check_idle_outputs("reset");
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;

      // Word store then word load at 8.
      xact(1'b1, 2'd3, 1'b0, 10'd8, 32'h1122_3344, 0);
      xact(1'b0, 2'd3, 1'b0, 10'd8, 32'h0, 0);
      check("word_load_direct", 64'({ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]}), 64'h1122_3344);

      // Byte 0x80 at 20: signed and unsigned loads.
      xact(1'b1, 2'd1, 1'b0, 10'd20, 32'hAABB_CC80, 1);
      xact(1'b0, 2'd1, 1'b1, 10'd20, 32'h0, 0);
      xact(1'b0, 2'd1, 1'b0, 10'd20, 32'h0, 0);
      xact(1'b0, 2'd2, 1'b1, 10'd20, 32'h0, 2);

      // Top-of-memory boundary: half at 123 fits, word at 122 faults, word at 121 fits.
      xact(1'b1, 2'd2, 1'b0, 10'd123, 32'h0000_F00D, 0);
      xact(1'b0, 2'd3, 1'b0, 10'd122, 32'h0, 0);
      xact(1'b1, 2'd3, 1'b0, 10'd122, 32'hDEAD_BEEF, 0);
      xact(1'b0, 2'd3, 1'b1, 10'd121, 32'h0, 0);
      xact(1'b0, 2'd1, 1'b0, 10'd125, 32'h0, 0);
      xact(1'b1, 2'd3, 1'b0, 10'd1022, 32'h1234_5678, 0);

      // Illegal size, then a response held off for three cycles.
      xact(1'b0, 2'd0, 1'b0, 10'd0, 32'h0, 0);
      xact(1'b1, 2'd0, 1'b0, 10'd4, 32'hFFFF_FFFF, 3);
      xact(1'b0, 2'd2, 1'b0, 10'd8, 32'h0, 3);

      // Reset during the ACCESS cycle of a word store at 40 abandons it.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size  = 2'd3;
      req_addr  = 10'd40;
      req_wdata = 32'hCAFE_BABE;
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      check("rst_pre_ctl", 64'(mem_control), 64'd3);
      reset = 1'b1;
      #1;
      check("rst_mid_ready", 64'(req_ready), 64'd1);
      check("rst_mid_rspv",  64'(rsp_valid), 64'd0);
      check("rst_mid_rdata", 64'(rsp_rdata), 64'd0);
      check_idle_outputs("rst_mid");
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      xact(1'b0, 2'd3, 1'b0, 10'd40, 32'h0, 0);

      // Randomized traffic, biased toward the top of memory.
      for (int t = 0; t < 300; t++) begin
         logic [1:0]        sz;
         logic [ADDR_W-1:0] a;
         sz = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
         case ($urandom_range(0, 3))
            0:       a = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            1:       a = ADDR_W'($urandom_range(115, 127));
            default: a = ADDR_W'($urandom_range(0, 127));
         endcase
         xact(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3));
      end

      bad = 0;
      for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== ref_mem[i]) bad++;
      check("mem_image", 64'(bad), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer sitting directly upstream of the byte-addressed external memory. Accepts one CPU data request (byte/half/word, read or write) per handshake, expands it into the memory's four per-lane byte addresses and size control, and bounds-checks the range against the memory size. Returns read data zero- or sign-extended, or a fault, through a response handshake.

## Interface
- MEM_SIZE, 125, number of implemented memory bytes; valid addresses 0..MEM_SIZE-1
- ADDR_W, 10, byte address width per lane
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  1 = byte, 2 = half, 3 = word, 0 = illegal
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  first byte address
- req_wdata  in  32  store data, little-endian lanes
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  out-of-range or illegal size
- mem_control  out  2  memory write size code; 0 = no write
- mem_address  out  4*ADDR_W  {A3,A2,A1,A0}
- mem_write  out  32  memory write data
- mem_read  in  32  combinational memory read {lane3..lane0}

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid: latch write/size/signed/addr/wdata. nbytes = 1/2/4 for size 1/2/3. If size==0 or addr+nbytes > MEM_SIZE (computed ADDR_W+1 bits wide), set fault, go RESP; otherwise go ACCESS.
- ACCESS (exactly one cycle): lane k (k<nbytes) = addr+k, truncated to ADDR_W; lanes k>=nbytes = addr (keeps memory validity check true). mem_write = latched wdata. mem_control = size if write, else 0. For loads, mem_read is captured at the closing edge: byte -> bits 7:0, half -> 15:0, word -> 31:0, upper bits zero- or sign-extended. Go RESP.
- RESP: rsp_valid=1, rsp_rdata/rsp_fault held stable; leave to IDLE on rsp_ready.
- Outside ACCESS: mem_control=0, mem_address=0, mem_write=0.
- Faulting requests never drive mem_control nonzero; rsp_rdata=0.
- Reset: state IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_control=0, mem_address=0, mem_write=0. Reset during ACCESS abandons the access; no write occurs unless the edge arrived before reset.

## Timing
- Accept on edge E0 (req_valid & req_ready). ACCESS spans E0..E1; memory write and read capture occur at E1. rsp_valid high from E1 until the edge where rsp_ready is sampled high.
- Fault: rsp_valid high from E0+1 edge... specifically directly after E0 (skips ACCESS).
- Minimum throughput: one request per 3 cycles (2 for faults) with rsp_ready tied high.
- req_ready low from E0 until return to IDLE; req inputs ignored while not IDLE.
- mem_* outputs registered; all change only on clock edges or reset.

## Configuration
- MAU_SIGN_EXT_EN defined: req_signed=1 sign-extends byte/half loads from bit 7/15.
- Not defined: req_signed ignored; all loads zero-extended; no sign-extension logic synthesised.

## Test plan
- Store word 0x11223344 at 8, then load word at 8 -> mem_control=3 for one cycle with lanes 11,10,9,8; load rsp_rdata=0x11223344, rsp_fault=0.
- Store byte 0x80 at 20, load byte signed at 20 -> 0xFFFFFF80 with MAU_SIGN_EXT_EN, 0x00000080 without; unsigned -> 0x00000080 both.
- Half store at 123 (MEM_SIZE=125) -> succeeds, lanes {123,123,124,123}; word load at 122 -> rsp_fault=1, rsp_rdata=0, mem_control stays 0.
- req_size=0 at addr 0 -> fault response one cycle after accept, no memory access.
- Hold rsp_ready=0 for 3 cycles after response -> rsp_valid and data stable, req_ready=0; released -> IDLE next cycle.
- Assert reset during ACCESS of a store -> all outputs zero, state IDLE, req_ready=1 after reset; store not observed on later load.
